// File: rtl/fifo_wconv_if.sv
// Handshake bundle for the width-converting FWFT FIFO.
// The producer/consumer side uses the master view and the FIFO uses the slave view.
interface fifo_wconv_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RATIO      = 2
);
  localparam int LW = $clog2(RATIO);

  logic                          clear;
  logic                          rd;
  logic                          wr;
  logic [RATIO*DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH-1:0]         r_data;
  logic                          empty;
  logic                          full;
  logic                          almost_empty;
  logic                          almost_full;
  logic [ADDR_WIDTH+LW:0]        count;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output clear, rd, wr, w_data,
    input  r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  clear, rd, wr, w_data,
    output r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_wconv.sv
// First-word-fall-through FIFO: writes RATIO lanes at once, reads one DATA_WIDTH lane per pop.
// Flags and count decode from registered pointers only.
module fifo_wconv #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RATIO      = 2,
  parameter int AF_LEVEL   = 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic          clk,
  input  logic          reset,
  fifo_wconv_if.slave   bus
);
  localparam int LW    = $clog2(RATIO);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + LW + 1;
  localparam int WW    = RATIO * DATA_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_P  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_L     = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [CW-1:0]       AE_L     = CW'(AE_LEVEL);
  localparam logic [LW-1:0]       LANE_ONE = LW'(1);
  localparam logic [LW-1:0]       LANE_MAX = LW'(RATIO - 1);

  logic [ADDR_WIDTH:0]    r_wptr;
  logic [ADDR_WIDTH:0]    r_rptr;
  logic [LW-1:0]          r_lane;
  logic                   r_ovf;
  logic                   r_udf;
  logic [WW-1:0]          r_mem [DEPTH];

  logic [ADDR_WIDTH:0]    w_used;
  logic [ADDR_WIDTH:0]    w_free;
  logic [CW-1:0]          w_count;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_last;
  logic                   w_rd_ok;
  logic                   w_pop;
  logic                   w_wr_ok;
  logic [WW-1:0]          w_head;
  logic [DATA_WIDTH-1:0]  w_lane;

  assign w_used  = r_wptr - r_rptr;
  assign w_free  = DEPTH_P - w_used;
  assign w_count = {w_used, {LW{1'b0}}} - CW'(r_lane);
  assign w_empty = (w_used == '0);
  assign w_full  = (w_used == DEPTH_P);
  assign w_last  = (r_lane == LANE_MAX);
  assign w_rd_ok = bus.rd && !w_empty;
  assign w_pop   = w_rd_ok && w_last;
  // Popping the final lane of the head frees its entry, so a write to a full FIFO fits.
  assign w_wr_ok = bus.wr && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lane <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else if (bus.clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lane <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_rd_ok) begin
        if (w_last) begin
          r_lane <= '0;
          r_rptr <= r_rptr + PTR_ONE;
        end else begin
          r_lane <= r_lane + LANE_ONE;
        end
      end else if (bus.rd) begin
        r_udf <= 1'b1;
      end
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end else if (bus.wr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !bus.clear && w_wr_ok) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= bus.w_data;
    end
  end

  assign w_head = r_mem[r_rptr[ADDR_WIDTH-1:0]];

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_lane == LW'(i)) begin
        w_lane = w_head[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.r_data       = w_empty ? '0 : w_lane;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.count        = w_count;
  assign bus.almost_empty = (w_count <= AE_L);
  assign bus.almost_full  = (w_free <= AF_L);
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_fifo_wconv.sv
// Scoreboard bench for fifo_wconv: lanes are queued on accepted writes and compared on pops.
module tb_fifo_wconv;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int R     = 2;
  localparam int AFL   = 1;
  localparam int AEL   = 1;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_wconv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RATIO(R)) bus();

  fifo_wconv #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RATIO(R), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         n_asrt = 0;
  int         n_fail = 0;
  logic [DW-1:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_used();
    return (q.size() + R - 1) / R;
  endfunction

  task automatic check_state(input string tag);
    logic [DW-1:0] exp_data;
    exp_data = (q.size() == 0) ? '0 : q[0];
    check({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    check({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(bus.full), 32'(m_used() == DEPTH));
    check({tag, ".ae"}, 32'(bus.almost_empty), 32'(q.size() <= AEL));
    check({tag, ".af"}, 32'(bus.almost_full), 32'((DEPTH - m_used()) <= AFL));
    check({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, ".udf"}, 32'(bus.underflow), 32'(m_udf));
    check({tag, ".rdata"}, 32'(bus.r_data), 32'(exp_data));
  endtask

  task automatic step(input logic rd, input logic wr, input logic [R*DW-1:0] d,
                      input logic clr, input string tag);
    bit m_empty, m_full, last, rd_ok, wr_ok;
    m_empty = (q.size() == 0);
    m_full  = (m_used() == DEPTH);
    last    = ((q.size() % R) == 1);
    rd_ok   = rd && !clr && !m_empty;
    wr_ok   = wr && !clr && (!m_full || (rd_ok && last));
    if (rd_ok) check({tag, ".pop"}, 32'(bus.r_data), 32'(q.pop_front()));
    bus.rd = rd; bus.wr = wr; bus.w_data = d; bus.clear = clr;
    @(posedge clk); #1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.clear = 1'b0;
    if (clr) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (rd && m_empty) m_udf = 1'b1;
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (wr_ok) for (int i = 0; i < R; i++) q.push_back(d[i*DW +: DW]);
    end
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R*DW-1:0] fill_words [5];
    fill_words = '{16'h1100, 16'h3322, 16'h5544, 16'h7766, 16'h9988};
    bus.rd = 1'b0; bus.wr = 1'b0; bus.clear = 1'b0; bus.w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("rst0");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // FWFT and lane order
    step(1'b0, 1'b1, 16'hBBAA, 1'b0, "w0");
    check("fwft", 32'(bus.r_data), 32'h0AA);
    check("fwft_cnt", 32'(bus.count), 32'd2);
    step(1'b1, 1'b0, '0, 1'b0, "r0");
    check("lane1", 32'(bus.r_data), 32'h0BB);
    check("ae1", 32'(bus.almost_empty), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, "r1");
    check("empty1", 32'(bus.empty), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, "r2");
    check("udf", 32'(bus.underflow), 32'd1);
    check("udf_cnt", 32'(bus.count), 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, "clr0");

    // Fill and overflow
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, fill_words[i], 1'b0, "fill");
    check("af", 32'(bus.almost_full), 32'd1);
    step(1'b0, 1'b1, fill_words[3], 1'b0, "fill3");
    check("full", 32'(bus.full), 32'd1);
    check("full_cnt", 32'(bus.count), 32'd8);
    step(1'b0, 1'b1, fill_words[4], 1'b0, "fill4");
    check("ovf", 32'(bus.overflow), 32'd1);

    // Full-boundary concurrency
    step(1'b1, 1'b1, 16'hFFEE, 1'b0, "fc0");
    check("fc0_cnt", 32'(bus.count), 32'd7);
    step(1'b1, 1'b1, 16'hDDCC, 1'b0, "fc1");
    check("fc1_cnt", 32'(bus.count), 32'd8);
    check("fc1_full", 32'(bus.full), 32'd1);
    repeat (8) step(1'b1, 1'b0, '0, 1'b0, "drain");
    check("drain_empty", 32'(bus.empty), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, "clr1");

    // Streaming across pointer wraps
    step(1'b0, 1'b1, 16'h0000, 1'b0, "s0");
    for (int i = 1; i < 12; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, "srd");
      step(1'b1, 1'b1, {8'(i), 8'(i)}, 1'b0, "srw");
      check("cmax", 32'(bus.count <= 8), 32'd1);
    end
    repeat (2) step(1'b1, 1'b0, '0, 1'b0, "stail");
    check("s_ovf", 32'(bus.overflow), 32'd0);
    check("s_udf", 32'(bus.underflow), 32'd0);
    check("s_empty", 32'(bus.empty), 32'd1);

    // Clear with pending write
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, fill_words[i], 1'b0, "cfill");
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, "crd");
    check("c_cnt5", 32'(bus.count), 32'd5);
    check("c_ovf", 32'(bus.overflow), 32'd1);
    step(1'b0, 1'b1, 16'h1234, 1'b1, "clr2");
    check("clr_empty", 32'(bus.empty), 32'd1);
    check("clr_cnt", 32'(bus.count), 32'd0);
    check("clr_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, "clr_idle");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, fill_words[i], 1'b0, "rfill");
    step(1'b1, 1'b0, '0, 1'b0, "rrd");
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_cnt", 32'(bus.count), 32'd0);
    check("arst_rdata", 32'(bus.r_data), 32'd0);
    check("arst_full", 32'(bus.full), 32'd0);
    check("arst_ovf", 32'(bus.overflow), 32'd0);
    check("arst_udf", 32'(bus.underflow), 32'd0);
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_state("post_rst");
    step(1'b0, 1'b1, 16'h5A4B, 1'b0, "pr_w");
    step(1'b1, 1'b0, '0, 1'b0, "pr_r0");
    step(1'b1, 1'b0, '0, 1'b0, "pr_r1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wconv.md
Name: fifo_wconv

Overview:
- Parametrised first-word-fall-through (FWFT) FIFO with a width-converting write port. Each write is RATIO×DATA_WIDTH bits wide, and data is read out one DATA_WIDTH lane at a time.
- Generalises the 2:1 write/read FIFO to any power-of-two ratio. Adds occupancy count, almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow flags.
- Sits between wide producers (bus/DMA side) and narrow consumers (serialisers, datapath lanes).

Parameters:
- DATA_WIDTH, 8, read-port width in bits (one lane).
- ADDR_WIDTH, 4, log2 of depth. Storage is 2^ADDR_WIDTH wide entries.
- RATIO, 2, lanes per write word. Legal values: 2, 4, 8. LW = log2(RATIO).
- AF_LEVEL, 1, almost_full asserts when free entries <= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when unread lanes <= AE_LEVEL.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low. 0 resets all state.
- clear, in, 1, synchronous flush.
- rd, in, 1, pop one lane.
- wr, in, 1, push one wide word.
- w_data, in, RATIO*DATA_WIDTH, write word. Lane 0 is bits [DATA_WIDTH-1:0].
- r_data, out, DATA_WIDTH, current head lane (FWFT).
- empty, out, 1, no unread lanes.
- full, out, 1, all entries occupied.
- almost_empty, out, 1, occupancy at or below AE_LEVEL lanes.
- almost_full, out, 1, free entries at or below AF_LEVEL.
- count, out, ADDR_WIDTH+LW+1, number of unread lanes (0..RATIO*2^ADDR_WIDTH).
- overflow, out, 1, sticky; a write was dropped.
- underflow, out, 1, sticky; a read was ignored.

Behaviour:
- State:
  - w_ptr, r_ptr: ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
  - r_lane: LW bits.
  - overflow, underflow: sticky flags.
  - Memory array: not reset.
- Reset values (while reset=0):
  - pointers and r_lane = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (provided AF_LEVEL < 2^ADDR_WIDTH).
  - overflow = 0, underflow = 0, r_data = 0.
- Flag and data derivation:
  - All flags and count are decoded from registered state only; no combinational path from rd/wr/w_data.
  - Entries used = w_ptr - r_ptr (modulo 2^(ADDR_WIDTH+1)).
  - full = (entries used == 2^ADDR_WIDTH).
  - empty = (entries used == 0).
  - count = entries used × RATIO - r_lane.
  - r_data = lane r_lane of mem[r_ptr] when not empty; 0 when empty.
- Read, when rd=1 and not empty:
  - If r_lane < RATIO-1: r_lane increments.
  - Else (last lane): r_lane returns to 0 and r_ptr increments, freeing the entry.
  - rd=1 while empty: ignored, underflow set to 1.
- Write, when wr=1:
  - Accepted if not full, or if the same cycle's rd pops the last lane of the head entry.
  - On accept: mem[w_ptr] <= w_data and w_ptr increments.
  - Otherwise dropped, memory unchanged, overflow set to 1.
  - A partially read head entry still counts as occupied.
- Simultaneous rd and wr:
  - Both act independently under the rules above.
  - When empty: the write is accepted, the read is ignored (underflow=1), and the new lane 0 appears on r_data the next cycle.
  - When neither empty nor full: count changes by RATIO-1.
- FWFT latency: data written at edge N is visible on r_data after edge N when the FIFO was empty.
- Wrap-around: pointers wrap naturally at 2^(ADDR_WIDTH+1). The wrap bit distinguishes full from empty.
- clear=1 at an edge:
  - w_ptr = r_ptr = 0, r_lane = 0, overflow = underflow = 0.
  - rd and wr are ignored that cycle.
  - clear has priority over rd/wr; reset has priority over everything.
- Reset mid-operation: immediate (asynchronous) return to reset values. Contents are discarded logically.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, RATIO=2, AF_LEVEL=1, AE_LEVEL=1):
- Reset: assert reset=0 mid-stream -> immediately empty=1, count=0, r_data=0x00, full=0, overflow=0, underflow=0.
- FWFT and lane order: write 0xBBAA into an empty FIFO -> next cycle r_data=0xAA, count=2. rd -> r_data=0xBB, count=1, almost_empty=1. rd -> empty=1. Extra rd -> underflow=1, count stays 0.
- Fill: write 0x1100, 0x3322, 0x5544 -> almost_full=1. Write 0x7766 -> full=1, count=8. 5th write 0x9988 -> dropped, overflow=1. Reads then return 00,11,22,…,77.
- Full-boundary concurrency: from full (count=8):
  - rd (lane 0) + wr -> write dropped, overflow=1, count=7.
  - Next cycle rd (lane 1) + wr 0xDDCC -> accepted, count=8, full=1, and 0xCC/0xDD are the last two lanes read.
- Wrap and stream: 12 consecutive writes of 0x0i0i with continuous rd -> no overflow or underflow, output order preserved across ≥2 pointer wraps, count never exceeds 8.
- clear: with count=5 and overflow=1, pulse clear together with wr -> next cycle empty=1, count=0, overflow=0, and the write is ignored.
